pipe_hazard_ctrl: RTL and testbench

PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

---
 rtl/pipe_hazard_ctrl.sv | 146 ++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard / stall controller: load-use bubbles, fetch and data-memory stalls, HLT drain.
// Optional performance counters are built only when PIPE_HAZARD_CTRL_PERF_EN is defined.
module pipe_hazard_ctrl (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] id_rs,
  input  logic [3:0] id_rt,
  input  logic       id_uses_rs,
  input  logic       id_uses_rt,
  input  logic       id_halt,
  input  logic       id_branch_taken,
  input  logic [3:0] ex_rd,
  input  logic       ex_mem_read,
  input  logic       imem_busy,
  input  logic       dmem_busy,
  output logic       pc_wen,
  output logic       if_id_wen,
  output logic       if_id_flush,
  output logic       id_ex_bubble,
  output logic       back_wen,
  output logic       halted,
`ifdef PIPE_HAZARD_CTRL_PERF_EN
  input  logic        perf_clr,
  output logic [15:0] stall_cnt,
  output logic [15:0] flush_cnt,
`endif
  output logic [1:0] state
);

  typedef enum logic [1:0] {
    RUN       = 2'd0,
    DMEM_WAIT = 2'd1,
    DRAIN     = 2'd2,
    HALTED    = 2'd3
  } state_t;

  state_t     state_q, state_d;
  state_t     saved_q, saved_d;
  logic [1:0] cnt_q, cnt_d;
  logic       load_use;
  logic       drain_mode;

  assign load_use = ex_mem_read && (ex_rd != 4'd0) &&
                    ((id_uses_rs && (id_rs == ex_rd)) || (id_uses_rt && (id_rt == ex_rd)));

  // A data-memory wait resumes whichever mode it interrupted.
  assign drain_mode = (state_q == DRAIN) || ((state_q == DMEM_WAIT) && (saved_q == DRAIN));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RUN;
      saved_q <= RUN;
      cnt_q   <= 2'd0;
    end else begin
      state_q <= state_d;
      saved_q <= saved_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    saved_d = saved_q;
    cnt_d   = cnt_q;
    if (state_q != HALTED) begin
      if (dmem_busy) begin
        state_d = DMEM_WAIT;
        if (state_q != DMEM_WAIT) saved_d = state_q;
      end else if (drain_mode) begin
        // The counter reaching zero this cycle ends the drain.
        if (cnt_q <= 2'd1) begin
          state_d = HALTED;
          cnt_d   = 2'd0;
        end else begin
          state_d = DRAIN;
          cnt_d   = cnt_q - 2'd1;
        end
      end else begin
        state_d = RUN;
        if (!load_use && id_halt) begin
          state_d = DRAIN;
          cnt_d   = 2'd3;
        end
      end
    end
  end

  always_comb begin
    pc_wen       = 1'b0;
    if_id_wen    = 1'b0;
    if_id_flush  = 1'b0;
    id_ex_bubble = 1'b0;
    back_wen     = 1'b0;
    halted       = 1'b0;
    if (!rst_n) begin
      if_id_flush  = 1'b1;
      id_ex_bubble = 1'b1;
    end else if (state_q == HALTED) begin
      halted = 1'b1;
    end else if (dmem_busy) begin
      pc_wen = 1'b0;
    end else if (drain_mode || load_use) begin
      id_ex_bubble = 1'b1;
      back_wen     = 1'b1;
    end else if (id_halt) begin
      if_id_wen   = 1'b1;
      if_id_flush = 1'b1;
      back_wen    = 1'b1;
    end else if (id_branch_taken) begin
      pc_wen      = 1'b1;
      if_id_wen   = 1'b1;
      if_id_flush = 1'b1;
      back_wen    = 1'b1;
    end else if (imem_busy) begin
      if_id_wen   = 1'b1;
      if_id_flush = 1'b1;
      back_wen    = 1'b1;
    end else begin
      pc_wen    = 1'b1;
      if_id_wen = 1'b1;
      back_wen  = 1'b1;
    end
  end

  assign state = state_q;

`ifdef PIPE_HAZARD_CTRL_PERF_EN
  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= 16'd0;
      flush_cnt <= 16'd0;
    end else if (perf_clr) begin
      stall_cnt <= 16'd0;
      flush_cnt <= 16'd0;
    end else begin
      if (!pc_wen && (state_q != HALTED)) stall_cnt <= sat_inc(stall_cnt);
      if (if_id_flush) flush_cnt <= sat_inc(flush_cnt);
    end
  end
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: behavioural model compared every cycle plus
// directed vectors with literal expectations. Perf-counter checks build with PIPE_HAZARD_CTRL_PERF_EN.
module tb_pipe_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] id_rs = 4'd0, id_rt = 4'd0, ex_rd = 4'd0;
  logic       id_uses_rs = 1'b0, id_uses_rt = 1'b0, id_halt = 1'b0, id_branch_taken = 1'b0;
  logic       ex_mem_read = 1'b0, imem_busy = 1'b0, dmem_busy = 1'b0;
  logic       pc_wen, if_id_wen, if_id_flush, id_ex_bubble, back_wen, halted;
  logic [1:0] state;
`ifdef PIPE_HAZARD_CTRL_PERF_EN
  logic        perf_clr = 1'b0;
  logic [15:0] stall_cnt, flush_cnt;
  logic        perf_en = 1'b0;
  logic [31:0] perf_exp = 32'd0;
`endif

  int          n_checks = 0;
  int          n_fail = 0;
  logic        lit_en = 1'b0;
  logic [7:0]  lit_exp = 8'd0;
  string       lit_name = "";
  logic [7:0]  obs;

  // Model state: halted, waiting on data memory, draining, drain cycles left.
  logic        m_halted = 1'b0, m_wait = 1'b0, m_drain = 1'b0;
  int          m_left = 0;

  pipe_hazard_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .id_rs(id_rs), .id_rt(id_rt), .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
    .id_halt(id_halt), .id_branch_taken(id_branch_taken),
    .ex_rd(ex_rd), .ex_mem_read(ex_mem_read),
    .imem_busy(imem_busy), .dmem_busy(dmem_busy),
    .pc_wen(pc_wen), .if_id_wen(if_id_wen), .if_id_flush(if_id_flush),
    .id_ex_bubble(id_ex_bubble), .back_wen(back_wen), .halted(halted),
`ifdef PIPE_HAZARD_CTRL_PERF_EN
    .perf_clr(perf_clr), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt),
`endif
    .state(state)
  );

  always #5 clk = ~clk;

  assign obs = {state, halted, pc_wen, if_id_wen, if_id_flush, id_ex_bubble, back_wen};

  function automatic logic lu();
    return ex_mem_read && (ex_rd != 4'd0) &&
           ((id_uses_rs && id_rs == ex_rd) || (id_uses_rt && id_rt == ex_rd));
  endfunction

  // Expected {state, halted, pc_wen, if_id_wen, if_id_flush, id_ex_bubble, back_wen}.
  function automatic logic [7:0] model_out();
    logic [1:0] st;
    if (!rst_n) return 8'h06;
    if (m_halted) return 8'hE0;
    st = m_wait ? 2'd1 : (m_drain ? 2'd2 : 2'd0);
    if (dmem_busy) return {st, 6'b000000};
    if (m_drain || lu()) return {st, 6'b000011};
    if (id_halt) return {st, 6'b001101};
    if (id_branch_taken) return {st, 6'b011101};
    if (imem_busy) return {st, 6'b001101};
    return {st, 6'b011001};
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_halted <= 1'b0;
      m_wait   <= 1'b0;
      m_drain  <= 1'b0;
      m_left   <= 0;
    end else if (!m_halted) begin
      if (dmem_busy) begin
        m_wait <= 1'b1;
      end else begin
        m_wait <= 1'b0;
        if (m_drain) begin
          m_left <= m_left - 1;
          if (m_left == 1) begin
            m_drain  <= 1'b0;
            m_halted <= 1'b1;
          end
        end else if (id_halt && !lu()) begin
          m_drain <= 1'b1;
          m_left  <= 3;
        end
      end
    end
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    check("model", {24'd0, obs}, {24'd0, model_out()});
    if (lit_en) check(lit_name, {24'd0, obs}, {24'd0, lit_exp});
`ifdef PIPE_HAZARD_CTRL_PERF_EN
    if (perf_en) check("perf", {stall_cnt, flush_cnt}, perf_exp);
`endif
  end

  // f = {rst_n, id_uses_rs, id_uses_rt, ex_mem_read, id_halt, id_branch_taken, imem_busy, dmem_busy}
  task automatic go(input logic [3:0] rs, input logic [3:0] rt, input logic [3:0] rd,
                    input logic [7:0] f, input string nm, input logic [7:0] exp);
    @(posedge clk);
    #1;
    {rst_n, id_uses_rs, id_uses_rt, ex_mem_read, id_halt, id_branch_taken, imem_busy, dmem_busy} = f;
    id_rs = rs;
    id_rt = rt;
    ex_rd = rd;
    lit_en = (nm != "");
    lit_name = nm;
    lit_exp = exp;
    @(negedge clk);
    #1;
    lit_en = 1'b0;
`ifdef PIPE_HAZARD_CTRL_PERF_EN
    perf_en = 1'b0;
`endif
  endtask

  initial begin
    go(0, 0, 0, 8'b0000_0000, "reset",        8'h06);
    go(0, 0, 0, 8'b1000_0000, "first_normal", 8'h19);
    go(3, 0, 3, 8'b1101_0000, "lu_rs",        8'h03);
    go(3, 0, 3, 8'b1100_0000, "lu_done",      8'h19);
    go(0, 0, 0, 8'b1101_0000, "rd_zero",      8'h19);
    go(0, 5, 5, 8'b1011_0000, "lu_rt",        8'h03);
    go(5, 5, 5, 8'b1001_0000, "lu_unused",    8'h19);
    go(0, 0, 0, 8'b1000_0110, "br_imem",      8'h1D);
    go(0, 0, 0, 8'b1000_0010, "imem",         8'h0D);
    // Load-use hazard frozen by four data-memory wait cycles.
    go(3, 0, 3, 8'b1101_0001, "dm1",          8'h00);
    go(3, 0, 3, 8'b1101_0001, "dm2",          8'h40);
    go(3, 0, 3, 8'b1101_0001, "dm3",          8'h40);
    go(3, 0, 3, 8'b1101_0001, "dm4",          8'h40);
    go(3, 0, 3, 8'b1101_0000, "dm_rel_lu",    8'h43);
    go(3, 0, 3, 8'b1100_0000, "after_bubble", 8'h19);
    go(0, 0, 0, 8'b1000_0001, "dm_run",       8'h00);
    go(0, 0, 0, 8'b1000_0100, "dm_rel_br",    8'h5D);
    go(0, 0, 0, 8'b1000_0000, "back_run",     8'h19);
    // Halt (with simultaneous branch) and drain.
    go(0, 0, 0, 8'b1000_1100, "halt_br",      8'h0D);
    go(0, 0, 0, 8'b1000_0000, "drain1",       8'h83);
    go(0, 0, 0, 8'b1000_0000, "drain2",       8'h83);
    go(0, 0, 0, 8'b1000_0000, "drain3",       8'h83);
    go(0, 0, 0, 8'b1000_0000, "halted",       8'hE0);
    go(3, 3, 3, 8'b1111_1111, "halted_ign",   8'hE0);
    go(0, 0, 0, 8'b0000_0000, "rst_halted",   8'h06);
    go(0, 0, 0, 8'b1000_0000, "rst_release",  8'h19);
    // Halt with a two-cycle data-memory wait in the middle of the drain.
    go(0, 0, 0, 8'b1000_1000, "halt2",        8'h0D);
    go(0, 0, 0, 8'b1000_0000, "d2_drain1",    8'h83);
    go(0, 0, 0, 8'b1000_0001, "d2_wait1",     8'h80);
    go(0, 0, 0, 8'b1000_0001, "d2_wait2",     8'h40);
    go(0, 0, 0, 8'b1000_0000, "d2_drain2",    8'h43);
    go(0, 0, 0, 8'b1000_0000, "d2_drain3",    8'h83);
    go(0, 0, 0, 8'b1000_0000, "d2_halted",    8'hE0);
    go(0, 0, 0, 8'b0000_0000, "rst2",         8'h06);
    go(0, 0, 0, 8'b1000_0000, "rst2_rel",     8'h19);
    // Reset while draining and while waiting on data memory.
    go(0, 0, 0, 8'b1000_1000, "halt3",        8'h0D);
    go(0, 0, 0, 8'b1000_0000, "d3_drain1",    8'h83);
    go(0, 0, 0, 8'b0000_0000, "rst_drain",    8'h06);
    go(0, 0, 0, 8'b1000_0000, "rst_drain_rel", 8'h19);
    go(0, 0, 0, 8'b1000_0001, "w1",           8'h00);
    go(0, 0, 0, 8'b1000_0001, "w2",           8'h40);
    go(0, 0, 0, 8'b0000_0001, "rst_wait",     8'h06);
    go(0, 0, 0, 8'b1000_0000, "rst_wait_rel", 8'h19);
    // Halt blocked by a load-use hazard does not start a drain.
    go(2, 0, 2, 8'b1101_1000, "halt_lu",      8'h03);
    go(0, 0, 0, 8'b1000_0000, "halt_lu_after", 8'h19);
`ifdef PIPE_HAZARD_CTRL_PERF_EN
    go(0, 0, 0, 8'b0000_0000, "perf_rst",     8'h06);
    for (int i = 0; i < 70000; i++) go(0, 0, 0, 8'b1000_0010, "", 8'h00);
    perf_en = 1'b1;
    perf_exp = 32'hFFFF_FFFF;
    go(0, 0, 0, 8'b1000_0010, "perf_sat", 8'h0D);
    perf_clr = 1'b1;
    perf_en = 1'b1;
    perf_exp = 32'h0000_0000;
    go(0, 0, 0, 8'b1000_0000, "perf_clr", 8'h19);
    perf_clr = 1'b0;
`endif
    @(negedge clk);
    #2;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
